// File: rtl/dev_rsp_ctrl.sv
// Response controller for the peripheral select path: one request at a time, waits on the
// selected device, returns data/error over valid/ready. Optional stall timeout: RSP_TIMEOUT_EN.
module dev_rsp_ctrl #(
   parameter int unsigned     XLEN           = 32,
   parameter int unsigned     TIMEOUT_CYCLES = 256,
   parameter logic [XLEN-1:0] ERR_DATA       = XLEN'(32'hDEAD_BEEF)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic            boot_dev_sel,
   input  logic            spi_dev_sel,
   input  logic            uart_dev_sel,
   input  logic            gpio_dev_sel,
   input  logic            boot_rdy,
   input  logic            spi_rdy,
   input  logic            uart_rdy,
   input  logic            gpio_rdy,
   input  logic [XLEN-1:0] boot_rdata,
   input  logic [XLEN-1:0] spi_rdata,
   input  logic [XLEN-1:0] uart_rdata,
   input  logic [XLEN-1:0] gpio_rdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   logic [3:0]        r_sel;
   logic              r_we;
   logic              r_rsp_valid;
   logic [XLEN-1:0]   r_rsp_rdata;
   logic              r_rsp_err;

   logic [3:0]        w_sel;
   logic              w_sel_onehot;
   logic [3:0]        w_rdy_vec;
   logic              w_rdy;
   logic [XLEN-1:0]   w_rdata_arr   [4];
   logic [XLEN-1:0]   w_masked_arr  [4];
   logic [XLEN-1:0]   w_rdata;

`ifdef RSP_TIMEOUT_EN
   localparam int unsigned       TW   = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]     TMAX = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0]                r_timer;
`endif

   assign w_sel        = {gpio_dev_sel, uart_dev_sel, spi_dev_sel, boot_dev_sel};
   assign w_sel_onehot = (w_sel != 4'd0) && ((w_sel & (w_sel - 4'd1)) == 4'd0);
   assign w_rdy_vec    = {gpio_rdy, uart_rdy, spi_rdy, boot_rdy};
   assign w_rdy        = |(w_rdy_vec & r_sel);

   assign w_rdata_arr[0] = boot_rdata;
   assign w_rdata_arr[1] = spi_rdata;
   assign w_rdata_arr[2] = uart_rdata;
   assign w_rdata_arr[3] = gpio_rdata;

   // Only the latched device contributes; unselected read data is masked to zero.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_mask
         assign w_masked_arr[gi] = r_sel[gi] ? w_rdata_arr[gi] : '0;
      end
   endgenerate

   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < 4; i++) begin
         w_rdata = w_rdata | w_masked_arr[i];
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_sel       <= 4'd0;
         r_we        <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
`ifdef RSP_TIMEOUT_EN
         r_timer     <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_sel <= w_sel;
                  r_we  <= req_we;
                  if (w_sel_onehot) begin
                     r_state <= S_WAIT;
`ifdef RSP_TIMEOUT_EN
                     r_timer <= '0;
`endif
                  end else begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= ERR_DATA;
                  end
               end
            end
            S_WAIT: begin
               // rdy is checked first so it wins over a coincident timeout.
               if (w_rdy) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= r_we ? '0 : w_rdata;
               end
`ifdef RSP_TIMEOUT_EN
               else if (r_timer == TMAX) begin
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_rdata <= ERR_DATA;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
`endif
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dev_rsp_ctrl.sv
// Scoreboard bench for dev_rsp_ctrl: stimulus pushes expected responses, a negedge monitor
// pops and compares on every response handshake. Timeout cases run when RSP_TIMEOUT_EN is set.
module tb_dev_rsp_ctrl;

   localparam int XLEN = 32;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid, req_ready, req_we;
   logic            boot_dev_sel, spi_dev_sel, uart_dev_sel, gpio_dev_sel;
   logic            boot_rdy, spi_rdy, uart_rdy, gpio_rdy;
   logic [XLEN-1:0] boot_rdata, spi_rdata, uart_rdata, gpio_rdata;
   logic            rsp_valid, rsp_ready, rsp_err;
   logic [XLEN-1:0] rsp_rdata;

   int checks   = 0;
   int failures = 0;
   logic [32:0] exp_q[$];   // {err, rdata}

   dev_rsp_ctrl #(.XLEN(XLEN), .TIMEOUT_CYCLES(16), .ERR_DATA(ERR)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .boot_dev_sel(boot_dev_sel), .spi_dev_sel(spi_dev_sel),
      .uart_dev_sel(uart_dev_sel), .gpio_dev_sel(gpio_dev_sel),
      .boot_rdy(boot_rdy), .spi_rdy(spi_rdy), .uart_rdy(uart_rdy), .gpio_rdy(gpio_rdy),
      .boot_rdata(boot_rdata), .spi_rdata(spi_rdata),
      .uart_rdata(uart_rdata), .gpio_rdata(gpio_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sel(input logic [3:0] s);
      {gpio_dev_sel, uart_dev_sel, spi_dev_sel, boot_dev_sel} = s;
   endtask

   // Present a request in IDLE and let it be accepted at the next edge.
   task automatic issue(input string name, input logic [3:0] s, input logic we);
      check({name, " req_ready"}, 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_we    = we;
      set_sel(s);
      tick();
      req_valid = 1'b0;
      req_we    = 1'b0;
      set_sel(4'b0000);
      $display("REQ %s sel=%b we=%0d", name, s, we);
   endtask

   // Monitor: every response handshake is compared against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp: got err=%0d rdata=%h expected no response", rsp_err, rsp_rdata);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("rsp", {31'd0, rsp_err, rsp_rdata}, {31'd0, e});
            $display("RSP err=%0d rdata=%h", rsp_err, rsp_rdata);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; set_sel(4'b0000);
      boot_rdy = 1'b0; spi_rdy = 1'b0; uart_rdy = 1'b0; gpio_rdy = 1'b0;
      boot_rdata = '0; spi_rdata = '0; uart_rdata = '0; gpio_rdata = '0;
      rsp_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      check("reset req_ready", 64'(req_ready), 64'd1);
      check("reset rsp_valid", 64'(rsp_valid), 64'd0);
      check("reset rsp_rdata", 64'(rsp_rdata), 64'd0);
      check("reset rsp_err",   64'(rsp_err),   64'd0);
      tick();

      // UART read, rdy at T+3 -> valid at T+4
      exp_q.push_back({1'b0, 32'h0000_00A5});
      issue("uart_rd", 4'b0100, 1'b0);
      for (int i = 0; i < 2; i++) begin
         check("uart wait rsp_valid", 64'(rsp_valid), 64'd0);
         check("uart wait req_ready", 64'(req_ready), 64'd0);
         tick();
      end
      uart_rdy = 1'b1; uart_rdata = 32'h0000_00A5;
      tick();
      uart_rdy = 1'b0; uart_rdata = '0;
      check("uart rsp_valid T+4", 64'(rsp_valid), 64'd1);
      tick();
      check("uart back idle", 64'(req_ready), 64'd1);

      // GPIO write with rsp_ready low; write returns 0 regardless of rdata
      rsp_ready = 1'b0;
      exp_q.push_back({1'b0, 32'h0});
      issue("gpio_wr", 4'b1000, 1'b1);
      gpio_rdy = 1'b1; gpio_rdata = 32'h5555_AAAA;
      tick();
      gpio_rdy = 1'b0; gpio_rdata = '0;
      req_valid = 1'b1; set_sel(4'b0100);   // ignored while busy
      for (int i = 0; i < 5; i++) begin
         check("hold rsp_valid", 64'(rsp_valid), 64'd1);
         check("hold rsp_rdata", 64'(rsp_rdata), 64'd0);
         check("hold req_ready", 64'(req_ready), 64'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      check("after hs req_ready", 64'(req_ready), 64'd1);
      check("after hs rsp_valid", 64'(rsp_valid), 64'd0);
      tick();
      req_valid = 1'b0; set_sel(4'b0000);
      check("next accepted req_ready", 64'(req_ready), 64'd0);
      exp_q.push_back({1'b0, 32'h0000_0077});
      uart_rdy = 1'b1; uart_rdata = 32'h0000_0077;
      tick();
      uart_rdy = 1'b0; uart_rdata = '0;
      check("min latency rsp_valid", 64'(rsp_valid), 64'd1);
      tick();

      // Decode errors: no select, then two selects
      exp_q.push_back({1'b1, ERR});
      issue("no_sel", 4'b0000, 1'b0);
      check("no_sel rsp_valid", 64'(rsp_valid), 64'd1);
      check("no_sel rsp_err",   64'(rsp_err),   64'd1);
      tick();
      exp_q.push_back({1'b1, ERR});
      issue("multi_sel", 4'b1010, 1'b0);
      check("multi_sel rsp_valid", 64'(rsp_valid), 64'd1);
      tick();

      // Wrong-device ready ignored
      issue("boot_rd", 4'b0001, 1'b0);
      spi_rdy = 1'b1; spi_rdata = 32'h1234_5678;
      tick();
      spi_rdy = 1'b0; spi_rdata = '0;
      for (int i = 0; i < 3; i++) begin
         check("wrong rdy rsp_valid", 64'(rsp_valid), 64'd0);
         tick();
      end
      exp_q.push_back({1'b0, 32'hCAFE_0001});
      boot_rdy = 1'b1; boot_rdata = 32'hCAFE_0001;
      tick();
      boot_rdy = 1'b0; boot_rdata = '0;
      check("boot rsp_valid", 64'(rsp_valid), 64'd1);
      tick();

`ifdef RSP_TIMEOUT_EN
      // Timeout after exactly 16 WAIT cycles
      exp_q.push_back({1'b1, ERR});
      issue("spi_timeout", 4'b0010, 1'b0);
      for (int i = 0; i < 16; i++) begin
         check("timeout wait rsp_valid", 64'(rsp_valid), 64'd0);
         tick();
      end
      check("timeout rsp_valid", 64'(rsp_valid), 64'd1);
      check("timeout rsp_err",   64'(rsp_err),   64'd1);
      tick();
      spi_rdy = 1'b1; spi_rdata = 32'h0BAD_0BAD;   // late rdy ignored
      tick();
      spi_rdy = 1'b0; spi_rdata = '0;
      check("late rdy rsp_valid", 64'(rsp_valid), 64'd0);
      // rdy on the 16th WAIT cycle beats the timeout
      exp_q.push_back({1'b0, 32'h0000_1616});
      issue("spi_edge", 4'b0010, 1'b0);
      for (int i = 0; i < 15; i++) tick();
      spi_rdy = 1'b1; spi_rdata = 32'h0000_1616;
      tick();
      spi_rdy = 1'b0; spi_rdata = '0;
      check("edge rsp_valid", 64'(rsp_valid), 64'd1);
      check("edge rsp_err",   64'(rsp_err),   64'd0);
      tick();
`else
      // Without a timer, WAIT persists until the selected rdy
      issue("spi_stall", 4'b0010, 1'b0);
      for (int i = 0; i < 20; i++) begin
         check("stall rsp_valid", 64'(rsp_valid), 64'd0);
         tick();
      end
      exp_q.push_back({1'b0, 32'h0000_2020});
      spi_rdy = 1'b1; spi_rdata = 32'h0000_2020;
      tick();
      spi_rdy = 1'b0; spi_rdata = '0;
      check("stall rsp_err", 64'(rsp_err), 64'd0);
      tick();
`endif

      // Reset in WAIT discards the transaction
      issue("uart_abort", 4'b0100, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort req_ready", 64'(req_ready), 64'd1);
      check("abort rsp_valid", 64'(rsp_valid), 64'd0);
      uart_rdy = 1'b1; uart_rdata = 32'h0000_00EE;
      tick();
      uart_rdy = 1'b0; uart_rdata = '0;
      for (int i = 0; i < 3; i++) begin
         check("abort late rdy rsp_valid", 64'(rsp_valid), 64'd0);
         tick();
      end

      check("scoreboard empty", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dev_rsp_ctrl.md
Name: dev_rsp_ctrl

Overview:
- Response side of the peripheral select path.
- Accepts one CPU bus request at a time, together with the one-hot device selects from the address decoder.
- Waits for the selected peripheral (boot ROM, SPI, UART, GPIO) to signal ready, then returns read data and error status to the CPU over a valid/ready response handshake.
- Flags unmapped and multiply-selected accesses, and optionally stalled ones, as bus errors.

Parameters:
- XLEN, 32, data width of the CPU bus and all peripheral read-data ports.
- TIMEOUT_CYCLES, 256, number of WAIT cycles before a timeout error is raised (only with RSP_TIMEOUT_EN). Legal range 2..65536.
- ERR_DATA, 32'hDEAD_BEEF, value returned on rsp_rdata for any error response (XLEN bits).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = write, 0 = read; sampled on acceptance.
- boot_dev_sel  in  1  decoder select, boot ROM; sampled on acceptance.
- spi_dev_sel  in  1  decoder select, SPI; sampled on acceptance.
- uart_dev_sel  in  1  decoder select, UART; sampled on acceptance.
- gpio_dev_sel  in  1  decoder select, GPIO; sampled on acceptance.
- boot_rdy / spi_rdy / uart_rdy / gpio_rdy  in  1 each  peripheral done strobe.
- boot_rdata / spi_rdata / uart_rdata / gpio_rdata  in  XLEN each  peripheral read data, valid with its rdy.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  CPU accepts response.
- rsp_rdata  out  XLEN  read data (0 for successful writes, ERR_DATA on error).
- rsp_err  out  1  bus error flag, valid with rsp_valid.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched select=0, latched we=0, timer=0. rst overrides every other event, including mid-transaction; any in-flight response is discarded and late peripheral rdy is ignored.
- States: IDLE, WAIT, RESP. req_ready = (state==IDLE), combinational from the state register.
- Request acceptance:
  - Accepted when req_valid && req_ready at edge T.
  - Latch the 4-bit select vector and req_we.
  - If the select count is not exactly 1 (zero or multiple selects): go to RESP at T+1 with rsp_err=1 and rsp_rdata=ERR_DATA. No peripheral is waited on.
  - Otherwise go to WAIT at T+1 with timer=0.
- WAIT:
  - Only the latched device's rdy is observed; rdy/rdata from unselected devices are ignored.
  - On the selected rdy=1 at edge E: go to RESP at E+1 with rsp_valid=1 and rsp_err=0. rsp_rdata = selected rdata for a read, 0 for a write.
  - Minimum latency: request accepted at T, rdy at T+1, rsp_valid at T+2.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake: go to IDLE next cycle, rsp_valid=0, rsp_err=0. rsp_rdata keeps its last value.
  - A new request is accepted no earlier than the cycle after the response handshake; there are no back-to-back overlapped transactions.
  - req_valid asserted while not in IDLE is ignored (not latched).
- All outputs except req_ready are registered.

Optional Feature:
- RSP_TIMEOUT_EN defined:
  - A $clog2(TIMEOUT_CYCLES)-bit timer increments every WAIT cycle.
  - If the timer reaches TIMEOUT_CYCLES-1 without the selected rdy: go to RESP with rsp_err=1 and rsp_rdata=ERR_DATA.
  - If rdy arrives on the same cycle as the timeout, rdy wins and there is no error.
  - A later rdy from the abandoned device is ignored.
- RSP_TIMEOUT_EN undefined:
  - No timer logic; WAIT persists until the selected rdy.
  - rsp_err is raised only for select decode errors.

Test Plan:
- UART read: accept with uart_dev_sel=1, uart_rdy at T+3 with uart_rdata=32'h0000_00A5 -> rsp_valid at T+4, rsp_rdata=32'h0000_00A5, rsp_err=0.
- GPIO write, rsp_ready held low 5 cycles: rsp_valid stays 1, rsp_rdata=0 stable, req_ready=0 throughout; release -> IDLE, next request accepted the following cycle.
- No select asserted: request accepted -> rsp_valid next cycle, rsp_err=1, rsp_rdata=32'hDEAD_BEEF. Same response with spi_dev_sel=1 and gpio_dev_sel=1 both asserted.
- Wrong-device ready: boot selected, spi_rdy pulsed with data 32'h1234_5678 -> no response; boot_rdy with 32'hCAFE_0001 -> rsp_rdata=32'hCAFE_0001.
- RSP_TIMEOUT_EN, TIMEOUT_CYCLES=16, SPI never ready -> rsp_err=1 after exactly 16 WAIT cycles. Repeat with spi_rdy on the 16th WAIT cycle -> rsp_err=0, data returned.
- rst asserted for one cycle during WAIT -> next cycle: IDLE, rsp_valid=0, req_ready=1. Subsequent uart_rdy produces no response.
